// File: rtl/npu_tile_scheduler_if.sv
// npu_tile_scheduler_if
//   Bundles every non-clock/reset signal of the tile scheduler.
//   slave  : scheduler view. Accepts commands, drives operand-buffer writes, PE
//            starts, result-buffer reads, read responses and status flags.
//   master : system view. Issues commands, answers PE starts (pe_done) and
//            result reads (res_rdata), observes everything else.
interface npu_tile_scheduler_if #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned TILE_BITS = 3,
    parameter int unsigned OP_W      = 3
);
    localparam int unsigned AddrW = 2 * TILE_BITS;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [7:0]           cmd_code;
    logic [TILE_BITS-1:0] cmd_tile_i;
    logic [TILE_BITS-1:0] cmd_tile_j;
    logic [OP_W-1:0]      cmd_op;
    logic [DATA_W-1:0]    cmd_data;

    logic                 buf_we;
    logic                 buf_sel;
    logic [AddrW-1:0]     buf_addr;
    logic [DATA_W-1:0]    buf_wdata;

    logic                 pe_start;
    logic [OP_W-1:0]      pe_op;
    logic [AddrW-1:0]     pe_addr;
    logic                 pe_done;

    logic                 res_re;
    logic [AddrW-1:0]     res_addr;
    logic [DATA_W-1:0]    res_rdata;

    logic                 rsp_valid;
    logic [DATA_W-1:0]    rsp_data;

    logic                 busy;
    logic                 done;
    logic                 err;

    modport slave (
        input  cmd_valid, cmd_code, cmd_tile_i, cmd_tile_j, cmd_op, cmd_data, pe_done, res_rdata,
        output cmd_ready, buf_we, buf_sel, buf_addr, buf_wdata, pe_start, pe_op, pe_addr,
               res_re, res_addr, rsp_valid, rsp_data, busy, done, err
    );

    modport master (
        output cmd_valid, cmd_code, cmd_tile_i, cmd_tile_j, cmd_op, cmd_data, pe_done, res_rdata,
        input  cmd_ready, buf_we, buf_sel, buf_addr, buf_wdata, pe_start, pe_op, pe_addr,
               res_re, res_addr, rsp_valid, rsp_data, busy, done, err
    );
endinterface

// File: rtl/npu_tile_scheduler.sv
// npu_tile_scheduler
//   Command controller between the SPI command decoder and the tile compute array.
//   WRITE (0x01) steers operand bytes alternately into buffer A/B per tile, START (0x02)
//   walks the PE over every tile in row-major order, READ (0x03) fetches one result.
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    npu_tile_scheduler_if.slave: command handshake, operand buffer write port,
//          PE start/done, result buffer read port, read response, busy/done/err status
module npu_tile_scheduler #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned TILE_BITS = 3,
    parameter int unsigned OP_W      = 3,
    parameter int unsigned TIMEOUT   = 1024
) (
    input logic                 clk,
    input logic                 rst_n,
    npu_tile_scheduler_if.slave bus
);
    localparam int unsigned AddrW  = 2 * TILE_BITS;
    localparam int unsigned NTiles = 1 << AddrW;
    localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

    localparam logic [7:0] CmdWrite = 8'h01;
    localparam logic [7:0] CmdStart = 8'h02;
    localparam logic [7:0] CmdRead  = 8'h03;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StRd} state_e;

    state_e              state_q, state_d;
    logic                ready_en_q;
    logic [AddrW-1:0]    idx_q, idx_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [NTiles-1:0]   phase_q, phase_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                buf_we_q, buf_we_d;
    logic                buf_sel_q, buf_sel_d;
    logic [AddrW-1:0]    buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0]   buf_wdata_q, buf_wdata_d;
    logic [AddrW-1:0]    res_addr_q, res_addr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic                cmd_fire;
    logic [AddrW-1:0]    cmd_addr;

    assign cmd_fire = bus.cmd_valid & bus.cmd_ready;
    assign cmd_addr = {bus.cmd_tile_i, bus.cmd_tile_j};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        op_d        = op_q;
        phase_d     = phase_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        buf_we_d    = 1'b0;
        buf_sel_d   = buf_sel_q;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        res_addr_d  = res_addr_q;
        rsp_valid_d = 1'b0;
        // Response data is passed straight through in the rsp_valid cycle, then held.
        rsp_data_d  = rsp_valid_q ? bus.res_rdata : rsp_data_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    unique case (bus.cmd_code)
                        CmdWrite: begin
                            buf_we_d          = 1'b1;
                            buf_sel_d         = phase_q[cmd_addr];
                            buf_addr_d        = cmd_addr;
                            buf_wdata_d       = bus.cmd_data;
                            phase_d[cmd_addr] = ~phase_q[cmd_addr];
                            done_d            = 1'b0;
                        end
                        CmdStart: begin
                            op_d    = bus.cmd_op;
                            idx_d   = '0;
                            done_d  = 1'b0;
                            phase_d = '0;
                            busy_d  = 1'b1;
                            state_d = StIssue;
                        end
                        CmdRead: begin
                            res_addr_d = cmd_addr;
                            state_d    = StRd;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                // pe_done wins over a timeout landing in the same cycle.
                if (bus.pe_done) begin
                    if (idx_q == '1) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + AddrW'(1);
                        state_d = StIssue;
                    end
                end else if (timer_q == TimerLast) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StRd: begin
                rsp_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ready_en_q  <= 1'b0;
            idx_q       <= '0;
            timer_q     <= '0;
            op_q        <= '0;
            phase_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_sel_q   <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            res_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            // Keeps cmd_ready low until the first edge after reset release.
            ready_en_q  <= 1'b1;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            op_q        <= op_d;
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            buf_we_q    <= buf_we_d;
            buf_sel_q   <= buf_sel_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            res_addr_q  <= res_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.cmd_ready = ready_en_q & (state_q == StIdle);
    assign bus.buf_we    = buf_we_q;
    assign bus.buf_sel   = buf_sel_q;
    assign bus.buf_addr  = buf_addr_q;
    assign bus.buf_wdata = buf_wdata_q;
    assign bus.pe_start  = (state_q == StIssue);
    assign bus.pe_op     = op_q;
    assign bus.pe_addr   = idx_q;
    assign bus.res_re    = (state_q == StRd);
    assign bus.res_addr  = res_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_d;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
